bcd_event_counter: RTL and testbench

Downstream stage of the mod-10 clock divider. It consumes the divider's `clk_div10_out` as a count-enable in the same `clk` domain and accumulates divide-by-10 events in a cascaded multi-digit BCD counter. It also provides a sticky overflow flag, a terminal-count indicator and a snapshot register for readout.

---
 rtl/bcd_event_counter.sv | 94 +++++++++
 tb/tb_bcd_event_counter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bcd_event_counter.sv
// bcd_event_counter
// Counts rising edges of the mod-10 divider output (div_in) in a cascaded
// multi-digit BCD counter. Also provides a sticky wrap flag, a terminal-count
// indicator and a snapshot register for readout.
//
// Handshake note: snap is a plain request. A capture takes place on every
// posedge where snap=1, with no back-pressure. snap_valid is the one-cycle
// acknowledge, and it is aligned with the updated snap_val.
module bcd_event_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_in,
  input  logic                  clr,
  input  logic                  hold,
  input  logic                  snap,
  output logic [4*DIGITS-1:0]   bcd_count,
  output logic                  tc,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   snap_val,
  output logic                  snap_valid
);

  logic                div_in_q;
  logic                rise;
  logic                inc;
  logic [4*DIGITS-1:0] count_inc;
  logic                carry;

  // Edge detect. div_in_q follows div_in unconditionally, so edges that arrive
  // during hold are consumed rather than deferred.
  assign rise = div_in & ~div_in_q;
  assign inc  = rise & ~hold & ~clr;

  // BCD increment. A digit advances only when every lower digit is 9.
  // A digit at 9 that receives a carry rolls to 0.
  always_comb begin
    count_inc = bcd_count;
    carry     = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (bcd_count[4*d +: 4] == 4'd9) begin
          count_inc[4*d +: 4] = 4'd0;
        end else begin
          count_inc[4*d +: 4] = bcd_count[4*d +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Terminal count is all digits at 9. It is taken from registers only.
  always_comb begin
    tc = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_count[4*d +: 4] != 4'd9) tc = 1'b0;
    end
  end

  // Edge-detect register. It is independent of hold and clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_in_q <= 1'b0;
    else      div_in_q <= div_in;
  end

  // Count and sticky overflow. clr has priority over an increment, so a wrap
  // and a clear on the same edge leave ovf low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_count <= '0;
      ovf       <= 1'b0;
    end else if (clr) begin
      bcd_count <= '0;
      ovf       <= 1'b0;
    end else if (inc) begin
      bcd_count <= count_inc;
      if (tc) ovf <= 1'b1;
    end
  end

  // Snapshot captures the count as it was before this edge. It is not
  // affected by clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_val   <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= snap;
      if (snap) snap_val <= bcd_count;
    end
  end

endmodule

// File: tb/tb_bcd_event_counter.sv
// tb_bcd_event_counter
// Directed test for bcd_event_counter with DIGITS=4. Inputs are driven just
// after each negedge. Outputs are checked on the following negedge, or
// between edges for the asynchronous reset case.
module tb_bcd_event_counter;

  logic        clk_tb;
  logic        rst;
  logic        div_in;
  logic        clr;
  logic        hold;
  logic        snap;
  logic [15:0] bcd_count;
  logic        tc;
  logic        ovf;
  logic [15:0] snap_val;
  logic        snap_valid;

  int vectors     = 0;
  int miscompares = 0;

  bcd_event_counter #(.DIGITS(4)) dut (
    .clk        (clk_tb),
    .rst        (rst),
    .div_in     (div_in),
    .clr        (clr),
    .hold       (hold),
    .snap       (snap),
    .bcd_count  (bcd_count),
    .tc         (tc),
    .ovf        (ovf),
    .snap_val   (snap_val),
    .snap_valid (snap_valid)
  );

  // Clock and reset generation
  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  // Comparison helper
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive n full pulses on div_in. Each pulse is 1 cycle high and 1 cycle low.
  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      div_in = 1'b1;
      @(negedge clk_tb);
      div_in = 1'b0;
      @(negedge clk_tb);
    end
  endtask

  initial begin
    rst = 1'b0; div_in = 1'b0; clr = 1'b0; hold = 1'b0; snap = 1'b0;

    // Reset held for 2 cycles
    @(negedge clk_tb);
    @(negedge clk_tb);
    check("reset_count", bcd_count, 16'h0000);
    check("reset_tc", tc, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    check("reset_snap_val", snap_val, 16'h0000);
    check("reset_snap_valid", snap_valid, 1'b0);
    rst = 1'b1;

    // Mod-10 divider model for 100 cycles: low for phases 0..4, high for 5..9
    for (int i = 0; i < 100; i++) begin
      div_in = ((i % 10) >= 5);
      @(negedge clk_tb);
      check("div_ovf", ovf, 1'b0);
      check("div_tc", tc, 1'b0);
      for (int d = 0; d < 4; d++)
        check("div_digit_le9", (bcd_count[4*d +: 4] <= 4'd9), 1'b1);
    end
    div_in = 1'b0;
    @(negedge clk_tb);
    check("div_count_10", bcd_count, 16'h0010);

    // Carry chain
    pulse(89);
    check("count_0099", bcd_count, 16'h0099);
    pulse(1);
    check("carry_0100", bcd_count, 16'h0100);
    check("carry_0100_tc", tc, 1'b0);
    pulse(9899);
    check("count_9999", bcd_count, 16'h9999);
    check("count_9999_tc", tc, 1'b1);
    check("count_9999_ovf", ovf, 1'b0);
    div_in = 1'b1;
    @(negedge clk_tb);
    check("wrap_count", bcd_count, 16'h0000);
    check("wrap_ovf", ovf, 1'b1);
    check("wrap_tc", tc, 1'b0);
    div_in = 1'b0;
    @(negedge clk_tb);

    // clr and rise together at 9999 with ovf already set
    pulse(9999);
    check("pre_clr_count", bcd_count, 16'h9999);
    check("pre_clr_ovf", ovf, 1'b1);
    div_in = 1'b1; clr = 1'b1;
    @(negedge clk_tb);
    div_in = 1'b0; clr = 1'b0;
    check("clr_rise_count", bcd_count, 16'h0000);
    check("clr_rise_ovf", ovf, 1'b0);
    check("clr_rise_tc", tc, 1'b0);
    @(negedge clk_tb);

    // hold
    pulse(5);
    check("hold_start", bcd_count, 16'h0005);
    hold = 1'b1;
    pulse(3);
    check("hold_frozen", bcd_count, 16'h0005);
    div_in = 1'b1;
    @(negedge clk_tb);
    hold = 1'b0;
    @(negedge clk_tb);
    @(negedge clk_tb);
    check("hold_release_high", bcd_count, 16'h0005);
    div_in = 1'b0;
    @(negedge clk_tb);
    pulse(1);
    check("hold_next_rise", bcd_count, 16'h0006);

    // Snapshot collisions
    clr = 1'b1;
    @(negedge clk_tb);
    clr = 1'b0;
    pulse(42);
    check("snap_pre", bcd_count, 16'h0042);
    snap = 1'b1; div_in = 1'b1;
    @(negedge clk_tb);
    snap = 1'b0; div_in = 1'b0;
    check("snap_rise_val", snap_val, 16'h0042);
    check("snap_rise_count", bcd_count, 16'h0043);
    check("snap_rise_valid", snap_valid, 1'b1);
    @(negedge clk_tb);
    check("snap_rise_valid_drop", snap_valid, 1'b0);
    snap = 1'b1; clr = 1'b1;
    @(negedge clk_tb);
    snap = 1'b0; clr = 1'b0;
    check("snap_clr_val", snap_val, 16'h0043);
    check("snap_clr_count", bcd_count, 16'h0000);
    check("snap_clr_valid", snap_valid, 1'b1);
    @(negedge clk_tb);
    check("snap_clr_valid_drop", snap_valid, 1'b0);

    // Asynchronous reset mid-count
    pulse(789);
    check("pre_reset_count", bcd_count, 16'h0789);
    #2;
    rst = 1'b0;
    div_in = 1'b1;
    #1;
    check("async_count", bcd_count, 16'h0000);
    check("async_ovf", ovf, 1'b0);
    check("async_tc", tc, 1'b0);
    check("async_snap_val", snap_val, 16'h0000);
    check("async_snap_valid", snap_valid, 1'b0);
    @(negedge clk_tb);
    rst = 1'b1;
    @(negedge clk_tb);
    check("post_reset_first_count", bcd_count, 16'h0001);
    div_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
